// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle CPU controller and its datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       i_or_d;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_we;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_we;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] ALUoper;
  logic       illegal_op;
  logic       retire;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, i_or_d, mem_rd, mem_wr, ir_we, mem_to_reg, reg_dst, reg_we,
           alu_src_a, alu_src_b, pc_src, ALUoper, illegal_op, retire, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, i_or_d, mem_rd, mem_wr, ir_we, mem_to_reg, reg_dst, reg_we,
           alu_src_a, alu_src_b, pc_src, ALUoper, illegal_op, retire, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle CPU: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives ALU operation, mux selects and write enables from the current state.
module multicycle_ctrl #(
  parameter logic [5:0] NONE_OP = 6'h3F
) (
  input logic                clk,
  input logic                rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    INIT      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    R_EXEC    = 4'd3,
    R_WB      = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs are decoded straight from the state so an async reset clears them at once.
  always_comb begin
    state_next     = FETCH;
    bus.pc_we      = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.ALUoper    = ALU_AND;
    bus.illegal_op = 1'b0;
    bus.retire     = 1'b0;
    bus.state      = state_reg;

    case (state_reg)
      FETCH: begin
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ALUoper   = ALU_ADD;
        bus.ir_we     = bus.mem_ready;
        bus.pc_we     = bus.mem_ready;
        state_next    = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        bus.alu_src_b = 2'b11;
        bus.ALUoper   = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:      state_next = R_EXEC;
          OP_LW, OP_SW:  state_next = MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_J:          state_next = JUMP;
          OP_ADDI:       state_next = I_EXEC;
          NONE_OP: begin
            bus.illegal_op = 1'b1;
            state_next     = FETCH;
          end
          default: begin
            bus.illegal_op = 1'b1;
            state_next     = FETCH;
          end
        endcase
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b00;
        state_next    = R_WB;
        case (bus.funct)
          6'h20: bus.ALUoper = ALU_ADD;
          6'h22: bus.ALUoper = ALU_SUB;
          6'h24: bus.ALUoper = ALU_AND;
          6'h25: bus.ALUoper = ALU_OR;
          6'h2A: bus.ALUoper = ALU_SLT;
          default: begin
            bus.ALUoper    = ALU_ADD;
            bus.illegal_op = 1'b1;
            state_next     = FETCH;
          end
        endcase
      end
      R_WB: begin
        bus.reg_dst = 1'b1;
        bus.reg_we  = 1'b1;
        bus.retire  = 1'b1;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ALUoper   = ALU_ADD;
        state_next    = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        bus.mem_rd = 1'b1;
        bus.i_or_d = 1'b1;
        state_next = bus.mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_we     = 1'b1;
        bus.retire     = 1'b1;
      end
      MEM_WRITE: begin
        bus.mem_wr = 1'b1;
        bus.i_or_d = 1'b1;
        bus.retire = bus.mem_ready;
        state_next = bus.mem_ready ? FETCH : MEM_WRITE;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b00;
        bus.ALUoper   = ALU_SUB;
        bus.pc_src    = 2'b01;
        bus.pc_we     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        bus.retire    = 1'b1;
      end
      JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_we  = 1'b1;
        bus.retire = 1'b1;
      end
      I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ALUoper   = ALU_ADD;
        state_next    = I_WB;
      end
      I_WB: begin
        bus.reg_we = 1'b1;
        bus.retire = 1'b1;
      end
      default: begin
        // INIT and the unused encodings 13-15 drive nothing and restart at FETCH.
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected state/output words are queued as
// each instruction is planned and popped every cycle as the controller steps.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.NONE_OP(6'h3F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] w;
  } exp_t;

  exp_t exp_q[$];
  bit   mr_q[$];
  int   errors = 0;
  int   checks = 0;
  int   gcyc   = 0;

  logic [17:0] dut_word;
  assign dut_word = {bus.pc_we, bus.i_or_d, bus.mem_rd, bus.mem_wr, bus.ir_we,
                     bus.mem_to_reg, bus.reg_dst, bus.reg_we, bus.alu_src_a,
                     bus.alu_src_b, bus.pc_src, bus.ALUoper, bus.illegal_op, bus.retire};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Expected control word per state, written from the state table.
  function automatic logic [17:0] exp_word(input logic [3:0] st, input bit mr,
                                           input logic [5:0] op, input logic [5:0] fn,
                                           input bit z);
    logic pcw, iod, mrd, mwr, irw, m2r, rdst, rwe, asa, ill, ret;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    {pcw, iod, mrd, mwr, irw, m2r, rdst, rwe, asa, ill, ret} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; aop = 3'b010; irw = mr; pcw = mr; end
      4'd2:  begin asb = 2'b11; aop = 3'b010;
                   ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08}); end
      4'd3:  begin asa = 1;
                   case (fn)
                     6'h20: aop = 3'b010;
                     6'h22: aop = 3'b110;
                     6'h24: aop = 3'b000;
                     6'h25: aop = 3'b001;
                     6'h2A: aop = 3'b111;
                     default: begin aop = 3'b010; ill = 1; end
                   endcase
             end
      4'd4:  begin rdst = 1; rwe = 1; ret = 1; end
      4'd5:  begin asa = 1; asb = 2'b10; aop = 3'b010; end
      4'd6:  begin mrd = 1; iod = 1; end
      4'd7:  begin m2r = 1; rwe = 1; ret = 1; end
      4'd8:  begin mwr = 1; iod = 1; ret = mr; end
      4'd9:  begin asa = 1; aop = 3'b110; psrc = 2'b01; pcw = (op == 6'h04) ? z : !z; ret = 1; end
      4'd10: begin psrc = 2'b10; pcw = 1; ret = 1; end
      4'd11: begin asa = 1; asb = 2'b10; aop = 3'b010; end
      4'd12: begin rwe = 1; ret = 1; end
      default: ;
    endcase
    return {pcw, iod, mrd, mwr, irw, m2r, rdst, rwe, asa, asb, psrc, aop, ill, ret};
  endfunction

  task automatic push(input logic [3:0] st, input bit mr, input logic [5:0] op,
                      input logic [5:0] fn, input bit z);
    exp_t e;
    e.st = st;
    e.w  = exp_word(st, mr, op, fn, z);
    exp_q.push_back(e);
    mr_q.push_back(mr);
  endtask

  // Queue the expected state sequence of one instruction; mem_ready is random where ignored.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input bit z,
                      input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(4'd1, 1'b0, op, fn, z);
    push(4'd1, 1'b1, op, fn, z);
    push(4'd2, 1'($urandom_range(0, 1)), op, fn, z);
    case (op)
      6'h00: begin
        push(4'd3, 1'($urandom_range(0, 1)), op, fn, z);
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})
          push(4'd4, 1'($urandom_range(0, 1)), op, fn, z);
      end
      6'h23: begin
        push(4'd5, 1'($urandom_range(0, 1)), op, fn, z);
        for (int i = 0; i < mw; i++) push(4'd6, 1'b0, op, fn, z);
        push(4'd6, 1'b1, op, fn, z);
        push(4'd7, 1'($urandom_range(0, 1)), op, fn, z);
      end
      6'h2B: begin
        push(4'd5, 1'($urandom_range(0, 1)), op, fn, z);
        for (int i = 0; i < mw; i++) push(4'd8, 1'b0, op, fn, z);
        push(4'd8, 1'b1, op, fn, z);
      end
      6'h04, 6'h05: push(4'd9, 1'($urandom_range(0, 1)), op, fn, z);
      6'h02: push(4'd10, 1'($urandom_range(0, 1)), op, fn, z);
      6'h08: begin
        push(4'd11, 1'($urandom_range(0, 1)), op, fn, z);
        push(4'd12, 1'($urandom_range(0, 1)), op, fn, z);
      end
      default: ;
    endcase
  endtask

  // Entered and left at posedge+1; done_at is the global cycle of retire/illegal_op.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input bit z, input int fw, input int mw, input int exp_len,
                     output int done_at);
    int cyc;
    int len;
    exp_t e;
    len = 0;
    done_at = 0;
    cyc = 0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    plan(op, fn, z, fw, mw);
    while (exp_q.size() != 0 && cyc < 40) begin
      bus.mem_ready = mr_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      cyc++;
      gcyc++;
      check($sformatf("%s_c%0d_state", tag, cyc), 32'(bus.state), 32'(e.st));
      check($sformatf("%s_c%0d_word", tag, cyc), 32'(dut_word), 32'(e.w));
      if (len == 0 && (bus.retire || bus.illegal_op)) begin
        len = cyc;
        done_at = gcyc;
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("%s_len", tag), 32'(len), 32'(exp_len));
    $display("txn %-8s op=%02h fn=%02h zero=%0d fetch_waits=%0d mem_waits=%0d cycles=%0d", tag, op, fn, z, fw, mw, len);
  endtask

  initial begin
    int d;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset and the single INIT cycle after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_word", 32'(dut_word), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_state", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1;

    run("sub", 6'h00, 6'h22, 1'b0, 0, 0, 4, d);
    run("add", 6'h00, 6'h20, 1'b0, 0, 0, 4, d);
    run("and", 6'h00, 6'h24, 1'b1, 0, 0, 4, d);
    run("or",  6'h00, 6'h25, 1'b0, 0, 0, 4, d);
    run("slt", 6'h00, 6'h2A, 1'b0, 0, 0, 4, d);
    run("lw_w", 6'h23, 6'h00, 1'b0, 2, 1, 8, d);
    run("lw",  6'h23, 6'h11, 1'b0, 0, 0, 5, d);
    run("sw_w", 6'h2B, 6'h00, 1'b0, 1, 2, 7, d);
    run("beq_t", 6'h04, 6'h00, 1'b1, 0, 0, 3, d);
    run("beq_n", 6'h04, 6'h00, 1'b0, 0, 0, 3, d);
    run("bne_t", 6'h05, 6'h00, 1'b0, 0, 0, 3, d);
    run("bne_n", 6'h05, 6'h00, 1'b1, 0, 0, 3, d);
    run("ill_op", 6'h3F, 6'h20, 1'b0, 0, 0, 2, d);
    run("ill_op2", 6'h10, 6'h20, 1'b0, 0, 0, 2, d);
    run("ill_fn", 6'h00, 6'h00, 1'b0, 0, 0, 3, d);

    // Back-to-back j, addi, sw retire at cycles 3, 7, 11 of the group.
    gcyc = 0;
    run("j",    6'h02, 6'h00, 1'b0, 0, 0, 3, d);
    check("b2b_j_at", 32'(d), 32'd3);
    run("addi", 6'h08, 6'h00, 1'b0, 0, 0, 4, d);
    check("b2b_addi_at", 32'(d), 32'd7);
    run("sw",   6'h2B, 6'h00, 1'b0, 0, 0, 4, d);
    check("b2b_sw_at", 32'(d), 32'd11);

    // Asynchronous reset during a MEM_WRITE stall.
    bus.opcode = 6'h2B;
    bus.mem_ready = 1'b1;
    d = 0;
    for (int i = 0; i < 10 && d == 0; i++) begin
      @(negedge clk);
      if (bus.state == 4'd5) d = 1;
    end
    check("rstw_reach_madr", 32'(d), 32'd1);
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rstw_stall_state", 32'(bus.state), 32'd8);
    check("rstw_stall_memwr", 32'(bus.mem_wr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_async_state", 32'(bus.state), 32'd0);
    check("rstw_async_memwr", 32'(bus.mem_wr), 32'd0);
    check("rstw_async_word", 32'(dut_word), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("rstw_init_state", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1;
    check("rstw_fetch_state", 32'(bus.state), 32'd1);
    check("rstw_fetch_memrd", 32'(bus.mem_rd), 32'd1);
    $display("txn rst_mid_sw done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle CPU. It drives the shared ALU datapath: it issues the ALUoper code and all mux selects and write enables, and it consumes the ALU zero flag.
- It decodes the instruction opcode and funct fields over FETCH/DECODE/EXEC/MEM/WB cycles.
- It stalls on a memory ready handshake.

Parameters:
- NONE_OP, 6'h3F, reserved opcode that always flags illegal_op (bench hook).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the access this cycle.
- pc_we  out  1  PC load enable (unconditional or branch-resolved).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- ir_we  out  1  instruction register load.
- mem_to_reg  out  1  register write data select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_we  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUoper  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  4  current state, for debug.

Behaviour:
- Single clock domain. The state register is asynchronously cleared by rst_n=0 to INIT (4'd0).
- All outputs are combinational from the state, plus mem_ready, zero, opcode and funct where listed below. Every output not listed for a state is 0.
- INIT (0): all outputs 0. Goes to FETCH unconditionally after the first clock with rst_n=1.
- FETCH (1):
  - Drives mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUoper=010, pc_src=00.
  - ir_we and pc_we equal mem_ready.
  - Stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1.
- DECODE (2): drives alu_src_a=0, alu_src_b=11, ALUoper=010 (precomputes the branch target). Next state by opcode:
  - 00 → R_EXEC
  - 23 (lw) or 2B (sw) → MEM_ADDR
  - 04 (beq) or 05 (bne) → BRANCH
  - 02 (j) → JUMP
  - 08 (addi) → I_EXEC
  - any other opcode, including NONE_OP → FETCH with illegal_op=1 for that cycle.
- R_EXEC (3): alu_src_a=1, alu_src_b=00. ALUoper from funct:
  - 20 → 010, 22 → 110, 24 → 000, 25 → 001, 2A → 111.
  - Any other funct: illegal_op=1, ALUoper=010, next state FETCH with no writeback.
  - Valid funct: next state R_WB.
- R_WB (4): reg_dst=1, reg_we=1, mem_to_reg=0, retire=1 → FETCH.
- MEM_ADDR (5): alu_src_a=1, alu_src_b=10, ALUoper=010. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (6): mem_rd=1, i_or_d=1. Holds until mem_ready=1, then → MEM_WB.
- MEM_WB (7): reg_dst=0, mem_to_reg=1, reg_we=1, retire=1 → FETCH.
- MEM_WRITE (8): mem_wr=1, i_or_d=1. Holds while mem_ready=0. When mem_ready=1: retire=1 → FETCH.
- BRANCH (9): alu_src_a=1, alu_src_b=00, ALUoper=110, pc_src=01.
  - pc_we = zero for beq, ~zero for bne.
  - retire=1 → FETCH.
- JUMP (10): pc_src=10, pc_we=1, retire=1 → FETCH.
- I_EXEC (11): alu_src_a=1, alu_src_b=10, ALUoper=010 → I_WB.
- I_WB (12): reg_dst=0, mem_to_reg=0, reg_we=1, retire=1 → FETCH.
- States 13–15 are unreachable. Treat them as INIT: all outputs 0, next state FETCH.
- Boundary conditions:
  - Reset asserted mid-instruction (for example during a MEM_WRITE stall) drops all outputs to 0 immediately. mem_wr must not remain high after rst_n falls.
  - mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
  - opcode and funct are only decoded in DECODE, R_EXEC, MEM_ADDR and BRANCH.
- Cycle counts with mem_ready tied to 1:
  - R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4.
  - Each mem_ready=0 cycle adds one cycle.

Test Plan:
- Reset: rst_n=0 while in MEM_WRITE → state=0 and all outputs 0 asynchronously. After release, one cycle in INIT, then FETCH with mem_rd=1.
- R-type: opcode=00, funct=22, mem_ready=1 → states 1,2,3,4. In R_EXEC ALUoper=110; in R_WB reg_we=1 and reg_dst=1; retire pulses once. Repeat with funct 20/24/25/2A → ALUoper 010/000/001/111.
- lw with 2 wait states in FETCH and 1 in MEM_READ → states 1,1,1,2,5,6,6,7, 8 cycles total. ir_we and pc_we are high only in the third FETCH cycle.
- Branches:
  - beq (04) with zero=1 → pc_we=1 and pc_src=01 in BRANCH; with zero=0 → pc_we=0.
  - bne (05) gives the inverse result.
  - Both take 3 cycles.
- Illegal: opcode=3F → illegal_op high for the DECODE cycle, then back to FETCH with no reg_we or mem_wr. R-type with funct=00 → illegal_op in R_EXEC and no R_WB.
- Back-to-back instructions j, addi, sw with mem_ready=1 → retire pulses at cycles 3, 7 and 11. I_WB has reg_we=1 and reg_dst=0. MEM_WRITE has mem_wr=1 and i_or_d=1.
